// File: rtl/aes_core_scheduler.sv
// Round-robin arbiter sharing one AES core between NUM_REQ requesters,
// with per-job watchdog, core reset on hang and tagged result return.
module aes_core_scheduler #(
  parameter int NUM_REQ      = 2,
  parameter int IDW          = 1,
  parameter int TIMEOUT_CYC  = 64,
  parameter int CORE_RST_CYC = 4
) (
  input  logic                   AES_clk,
  input  logic                   AES_rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*128-1:0] req_data,
  input  logic [NUM_REQ*128-1:0] req_key,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [127:0]           rsp_data,
  output logic [IDW-1:0]         rsp_id,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   core_rst_n,
  output logic                   core_en,
  output logic [127:0]           core_data_in,
  output logic [127:0]           core_key_in,
  input  logic [127:0]           core_data_out,
  input  logic                   core_data_out_valid
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam int FW = $clog2(CORE_RST_CYC + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, RESP} state_t;

  state_t               state, state_nx;
  logic [IDW-1:0]       last_grant, grant, id_q;
  logic [CW-1:0]        cnt;
  logic [FW-1:0]        fcnt;
  logic [127:0]         sel_data, sel_key, rsp_data_q;
  logic [NUM_REQ-1:0]   grant_oh;
  logic                 rsp_err_q, rst_done, found, any_req;

  assign any_req = |req_valid;

  // Search starts just past the last winner so nobody starves.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++)
      for (int i = 0; i < NUM_REQ; i++)
        if (!found && req_valid[i] &&
            (i == (int'(last_grant) + k) % NUM_REQ)) begin
          found = 1'b1;
          grant = IDW'(i);
        end
  end

  always_comb begin
    sel_data = '0;
    sel_key  = '0;
    grant_oh = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant == IDW'(i)) begin
        sel_data    = req_data[128*i +: 128];
        sel_key     = req_key[128*i +: 128];
        grant_oh[i] = 1'b1;
      end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (any_req) state_nx = RUN;
      RUN: begin
        if (core_data_out_valid)
          state_nx = RESP;
        else if (cnt == CW'(TIMEOUT_CYC - 1))
          state_nx = FLUSH;
      end
      FLUSH: if (fcnt == FW'(CORE_RST_CYC - 1)) state_nx = RESP;
      RESP:  if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      state        <= IDLE;
      last_grant   <= IDW'(NUM_REQ - 1);
      id_q         <= '0;
      cnt          <= '0;
      fcnt         <= '0;
      core_data_in <= '0;
      core_key_in  <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      rst_done     <= 1'b0;
    end else begin
      state    <= state_nx;
      rst_done <= 1'b1;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            core_data_in <= sel_data;
            core_key_in  <= sel_key;
            id_q         <= grant;
            last_grant   <= grant;
            cnt          <= '0;
          end
        end
        RUN: begin
          cnt  <= cnt + CW'(1);
          fcnt <= '0;
          if (core_data_out_valid) begin
            rsp_data_q <= core_data_out;
            rsp_err_q  <= 1'b0;
          end
        end
        FLUSH: begin
          fcnt <= fcnt + FW'(1);
          if (fcnt == FW'(CORE_RST_CYC - 1)) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state == IDLE && any_req && !AES_rst) ? grant_oh : '0;
  assign core_en    = (state == RUN);
  assign core_rst_n = rst_done && (state != FLUSH);
  assign busy       = (state != IDLE);
  assign rsp_valid  = (state == RESP);
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = id_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_aes_core_scheduler.sv
// Directed bench for aes_core_scheduler with a latency-programmable
// stand-in core whose output is data ^ key ^ MAGIC.
module tb_aes_core_scheduler;

  localparam int NR = 2;
  localparam int TO = 64;
  localparam int CR = 4;
  localparam logic [127:0] MAGIC = 128'h5a5a_0f0f_c3c3_9696_1234_5678_9abc_def0;

  logic              clk, AES_rst;
  logic [NR-1:0]     req_valid, req_ready;
  logic [NR*128-1:0] req_data, req_key;
  logic              rsp_valid, rsp_ready, rsp_err, busy;
  logic [127:0]      rsp_data;
  logic [0:0]        rsp_id;
  logic              core_rst_n, core_en, core_data_out_valid;
  logic [127:0]      core_data_in, core_key_in, core_data_out;

  logic [127:0] pd [NR];
  logic [127:0] pk [NR];
  int n_vec, n_bad;
  int lat, ccnt;
  bit never;

  aes_core_scheduler #(
    .NUM_REQ(NR), .IDW(1), .TIMEOUT_CYC(TO), .CORE_RST_CYC(CR)
  ) dut (
    .AES_clk(clk), .AES_rst(AES_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .busy(busy), .core_rst_n(core_rst_n), .core_en(core_en),
    .core_data_in(core_data_in), .core_key_in(core_key_in),
    .core_data_out(core_data_out),
    .core_data_out_valid(core_data_out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk)
    if (!core_en || !core_rst_n) ccnt <= 0;
    else ccnt <= ccnt + 1;

  assign core_data_out = core_data_in ^ core_key_in ^ MAGIC;
  assign core_data_out_valid = core_en && !never && (ccnt == lat - 1);

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic do_job(input int g, input int lat_e, input bit err_e);
    int n, en, lo;
    logic [NR-1:0] oh;
    logic [127:0] exp_d;
    lat   = lat_e;
    never = err_e;
    oh    = '0;
    oh[g] = 1'b1;
    #1 chk("grant", req_ready, oh);
    @(negedge clk);
    req_valid[g] = 1'b0;
    chk("en_start", core_en, 1);
    chk("rst_n_hi", core_rst_n, 1);
    chk("din", core_data_in, pd[g]);
    chk("kin", core_key_in, pk[g]);
    chk("ready_run", req_ready, 0);
    n = 0; en = 0; lo = 0;
    while (!rsp_valid && n < 400) begin
      if (core_en) en++;
      if (!core_rst_n) lo++;
      @(negedge clk);
      n++;
    end
    chk("rsp_wait", rsp_valid, 1);
    exp_d = err_e ? 128'h0 : (pd[g] ^ pk[g] ^ MAGIC);
    chk("rsp_data", rsp_data, exp_d);
    chk("rsp_id", rsp_id, g);
    chk("rsp_err", rsp_err, err_e);
    chk("en_resp", core_en, 0);
    chk("ready_resp", req_ready, 0);
    chk("latency", n, err_e ? TO + CR : lat_e);
    chk("en_cycles", en, err_e ? TO : lat_e);
    chk("rst_cycles", lo, err_e ? CR : 0);
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 0);
    chk("gap_en", core_en, 0);
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    lat = 4; never = 0;
    pd[0] = 128'h00000084_00000000_00000000_00000000;
    pk[0] = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
    pd[1] = 128'h01234567_89abcdef_fedcba98_76543210;
    pk[1] = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    req_data  = {pd[1], pd[0]};
    req_key   = {pk[1], pk[0]};
    req_valid = '0;
    rsp_ready = 1'b0;
    AES_rst   = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rst_n", core_rst_n, 0);
    chk("rst_en", core_en, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_rspd", rsp_data, 0);
    chk("rst_din", core_data_in, 0);
    AES_rst = 1'b0;
    @(negedge clk);
    chk("rel_rst_n", core_rst_n, 1);

    // single job from req0
    req_valid = 2'b01;
    do_job(0, 5, 0);
    release_rsp();

    // round robin from reset
    AES_rst = 1'b1;
    @(negedge clk);
    AES_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req_valid = 2'b11;
      do_job(k % 2, 3 + k, 0);
      if (k == 3) req_valid = '0;
      release_rsp();
    end

    // watchdog abort, then a normal job
    req_valid = 2'b01;
    do_job(0, 0, 1);
    release_rsp();
    req_valid = 2'b10;
    do_job(1, 7, 0);
    release_rsp();

    // consumer back-pressure
    req_valid = 2'b01;
    do_job(0, 3, 0);
    req_valid = 2'b11;
    repeat (20) begin
      @(negedge clk);
      chk("hold_v", rsp_valid, 1);
      chk("hold_d", rsp_data, pd[0] ^ pk[0] ^ MAGIC);
      chk("hold_id", rsp_id, 0);
      chk("hold_rdy", req_ready, 0);
      chk("hold_en", core_en, 0);
    end
    release_rsp();
    do_job(1, 3, 0);
    req_valid = '0;
    release_rsp();

    // reset mid-RUN
    req_valid = 2'b01;
    lat = 50;
    #1 chk("r5_grant", req_ready, 2'b01);
    @(negedge clk);
    req_valid = '0;
    repeat (5) @(negedge clk);
    chk("r5_en", core_en, 1);
    AES_rst = 1'b1;
    @(negedge clk);
    chk("r5_en0", core_en, 0);
    chk("r5_rst_n", core_rst_n, 0);
    chk("r5_busy", busy, 0);
    chk("r5_rspv", rsp_valid, 0);
    chk("r5_din", core_data_in, 0);
    chk("r5_rspd", rsp_data, 0);
    AES_rst = 1'b0;
    req_valid = 2'b10;
    do_job(1, 4, 0);
    release_rsp();

    // valid on the last watchdog cycle wins
    req_valid = 2'b01;
    do_job(0, TO, 0);
    release_rsp();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

endmodule
